bus_arbiter: RTL and testbench

Round-robin arbiter and tenure sequencer for the shared system bus (BUS_addr/BUS_data/BUS_req/BUS_ready/BUS_RW). It sits beside the bus controller, takes one request line per bus master (I-cache, D-cache, DMA engines), and issues a one-hot grant. It holds the grant across multi-beat transfers such as cache line fills and enforces fairness through a beat limit. It also recovers the bus from a slave that never answers.

---
 rtl/bus_arbiter_pkg.sv | 28 ++
 rtl/bus_arbiter_if.sv | 30 +++
 rtl/bus_arbiter_rr_pick.sv | 33 +++
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, master count and
// master index assignments used across the bus fabric.
package bus_arbiter_pkg;

  localparam int unsigned N_MASTERS_DEFAULT = 8;

  // Master index assignments on the shared bus
  localparam int unsigned MST_IC   = 0;
  localparam int unsigned MST_DC   = 1;
  localparam int unsigned MST_DMA0 = 2;
  localparam int unsigned MST_DMA1 = 3;
  localparam int unsigned MST_DMA2 = 4;
  localparam int unsigned MST_DMA3 = 5;
  localparam int unsigned MST_DMA4 = 6;
  localparam int unsigned MST_DMA5 = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Round-robin successor of a master index, wrapping at n
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and beat handshake between the bus masters, the slave
// side and the arbiter.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = N_MASTERS_DEFAULT,
  parameter int unsigned IDX_W     = $clog2(N_MASTERS)
);

  logic [N_MASTERS-1:0] DMA;
  logic                 BUS_req;
  logic                 BUS_ready;
  logic [N_MASTERS-1:0] grant;
  logic [IDX_W-1:0]     owner;
  logic                 busy;
  logic                 bus_err;

  // Bus side: requesters and the slave completion strobe
  modport master (
    output DMA, BUS_req, BUS_ready,
    input  grant, owner, busy, bus_err
  );

  // Arbiter side
  modport slave (
    input  DMA, BUS_req, BUS_ready,
    output grant, owner, busy, bus_err
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// start pointer, wrapping around.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N     = N_MASTERS_DEFAULT,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the start pointer upward with wrap; first hit wins
  always_comb begin
    logic [IDX_W-1:0] j;
    j       = '0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IDX_W'((32'(i_start) + k) % N);
      if (!o_valid && i_req[j]) begin
        o_valid    = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = j;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with tenure hold, beat-limit preemption and
// stuck-slave timeout recovery.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = N_MASTERS_DEFAULT,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         clr,
  bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(N_MASTERS);
  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [IDX_W-1:0]     r_rr;
  logic [IDX_W-1:0]     w_rr_nxt;
  logic [BEAT_W-1:0]    r_beats;
  logic [BEAT_W-1:0]    w_beats_nxt;
  logic [WAIT_W-1:0]    r_wait;
  logic [WAIT_W-1:0]    w_wait_nxt;
  logic [N_MASTERS-1:0] r_grant;
  logic [N_MASTERS-1:0] w_grant_nxt;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     w_owner_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_bus_err;
  logic                 w_bus_err_nxt;

  logic [N_MASTERS-1:0] w_pick_onehot;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_beat;
  logic                 w_wait_cycle;
  logic                 w_timeout;
  logic                 w_others;
  logic                 w_exit_done;
  logic                 w_exit_preempt;
  logic                 w_exit;

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (bus.DMA),
    .i_start (r_rr),
    .o_grant (w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_beat       = bus.BUS_req & bus.BUS_ready;
  assign w_wait_cycle = bus.BUS_req & ~bus.BUS_ready;
  // Compare against TIMEOUT-1 so the abort lands on the edge where the
  // wait count would reach TIMEOUT.
  assign w_timeout    = w_wait_cycle && (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_others     = |(bus.DMA & ~(N_MASTERS'(1) << r_owner));
  assign w_exit_done  = !bus.DMA[r_owner] && !bus.BUS_req;
  assign w_exit_preempt = (r_beats >= BEAT_W'(MAX_BEATS)) && w_others && !bus.BUS_req;
  assign w_exit       = w_timeout || w_exit_done || w_exit_preempt;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = OWN;
      OWN:     if (w_exit)       w_state_nxt = RELEASE;
      RELEASE:                   w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // Next values for grant outputs, rr pointer and tenure counters
  always_comb begin
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_busy_nxt    = r_busy;
    w_bus_err_nxt = 1'b0;
    w_rr_nxt      = r_rr;
    w_beats_nxt   = r_beats;
    w_wait_nxt    = r_wait;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_onehot;
          w_owner_nxt = w_pick_idx;
          w_busy_nxt  = 1'b1;
          w_rr_nxt    = IDX_W'(rr_next(32'(w_pick_idx), N_MASTERS));
          w_beats_nxt = '0;
          w_wait_nxt  = '0;
        end
      end
      OWN: begin
        if (w_exit) begin
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_bus_err_nxt = w_timeout;
          w_beats_nxt   = '0;
          w_wait_nxt    = '0;
        end else begin
          if (w_beat && (r_beats < BEAT_W'(MAX_BEATS)))
            w_beats_nxt = r_beats + BEAT_W'(1);
          w_wait_nxt = w_wait_cycle ? (r_wait + WAIT_W'(1)) : '0;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered outputs, rr pointer and counters
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_grant   <= '0;
      r_owner   <= IDX_W'(MST_IC);
      r_busy    <= 1'b0;
      r_bus_err <= 1'b0;
      r_rr      <= '0;
      r_beats   <= '0;
      r_wait    <= '0;
    end else begin
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_busy    <= w_busy_nxt;
      r_bus_err <= w_bus_err_nxt;
      r_rr      <= w_rr_nxt;
      r_beats   <= w_beats_nxt;
      r_wait    <= w_wait_nxt;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.owner   = r_owner;
  assign bus.busy    = r_busy;
  assign bus.bus_err = r_bus_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario bench for bus_arbiter: expected grants are queued as requests
// are driven and popped when a grant appears.
module tb_bus_arbiter;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic clr;

  bus_arbiter_if #(.N_MASTERS(N)) bus ();

  bus_arbiter #(
    .N_MASTERS (N),
    .MAX_BEATS (16),
    .TIMEOUT   (255)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clr           = 1'b0;
    bus.DMA       = '0;
    bus.BUS_req   = 1'b0;
    bus.BUS_ready = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    tick();
  endtask

  // Advance until a grant is visible or the budget runs out
  task automatic wait_grant(input int max_cyc, output int cyc, output logic [N-1:0] g);
    cyc = 0;
    while (bus.grant == '0 && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    g = bus.grant;
  endtask

  task automatic test_reset();
    clr           = 1'b0;
    bus.DMA       = 8'hFF;
    bus.BUS_req   = 1'b0;
    bus.BUS_ready = 1'b0;
    #3;
    checks++;
    if (bus.grant !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h expected 00", bus.grant); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.owner !== 3'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", bus.owner); end
    checks++;
    if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.bus_err); end
    tick();
    tick();
    checks++;
    if (bus.grant !== 8'h00) begin errors++; $display("FAIL reset_hold: got %h expected 00", bus.grant); end
  endtask

  task automatic test_single();
    logic [N-1:0] e;
    apply_reset();
    bus.DMA = 8'h01;
    exp_q.push_back(8'h01);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.grant !== e) begin errors++; $display("FAIL single_grant: got %h expected %h", bus.grant, e); end
    checks++;
    if (bus.busy !== 1'b1 || bus.owner !== 3'd0) begin
      errors++; $display("FAIL single_owner: got busy=%b owner=%0d expected busy=1 owner=0", bus.busy, bus.owner);
    end
    bus.BUS_req   = 1'b1;
    bus.BUS_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.grant !== 8'h01) begin errors++; $display("FAIL single_hold%0d: got %h expected 01", i, bus.grant); end
    end
    bus.BUS_req   = 1'b0;
    bus.BUS_ready = 1'b0;
    bus.DMA       = 8'h00;
    tick();
    checks++;
    if (bus.grant !== 8'h00 || bus.busy !== 1'b0 || bus.bus_err !== 1'b0) begin
      errors++; $display("FAIL single_release: got grant=%h busy=%b err=%b expected 00/0/0", bus.grant, bus.busy, bus.bus_err);
    end
    repeat (3) tick();
    checks++;
    if (bus.grant !== 8'h00) begin errors++; $display("FAIL single_idle: got %h expected 00", bus.grant); end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [N-1:0] g, e;
    apply_reset();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h01);
    bus.DMA = 8'h85;
    for (int r = 0; r < 4; r++) begin
      wait_grant(6, cyc, g);
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rr_order%0d: got %h expected %h", r, g, e); end
      checks++;
      if (cyc != ((r == 0) ? 1 : 2)) begin
        errors++; $display("FAIL rr_latency%0d: got %0d expected %0d", r, cyc, (r == 0) ? 1 : 2);
      end
      bus.BUS_req   = 1'b1;
      bus.BUS_ready = 1'b1;
      tick();
      bus.BUS_req   = 1'b0;
      bus.BUS_ready = 1'b0;
      bus.DMA       = 8'h85 & ~g;
      tick();
      checks++;
      if (bus.grant !== 8'h00) begin errors++; $display("FAIL rr_gap%0d: got %h expected 00", r, bus.grant); end
      bus.DMA = 8'h85;
    end
    bus.DMA = 8'h00;
  endtask

  task automatic test_preempt();
    int cyc, beats;
    logic released, early;
    logic [N-1:0] g, e;
    apply_reset();
    bus.DMA = 8'h01;
    exp_q.push_back(8'h01);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.grant !== e) begin errors++; $display("FAIL pre_first: got %h expected %h", bus.grant, e); end
    beats    = 0;
    released = 1'b0;
    for (int b = 1; b <= 40 && !released; b++) begin
      bus.BUS_req   = 1'b1;
      bus.BUS_ready = 1'b1;
      tick();
      beats         = b;
      bus.BUS_req   = 1'b0;
      bus.BUS_ready = 1'b0;
      if (b == 3) bus.DMA = 8'h03;
      tick();
      if (bus.grant == 8'h00) released = 1'b1;
    end
    checks++;
    if (!released || beats != 16) begin
      errors++; $display("FAIL pre_limit: got released=%b after %0d beats expected released after 16", released, beats);
    end
    exp_q.push_back(8'h02);
    wait_grant(6, cyc, g);
    e = exp_q.pop_front();
    checks++;
    if (g !== e || cyc != 2) begin errors++; $display("FAIL pre_next: got %h after %0d expected %h after 2", g, cyc, e); end
    // Master 1 leaves; master 0 is alone and runs past the limit
    bus.DMA = 8'h01;
    tick();
    exp_q.push_back(8'h01);
    wait_grant(6, cyc, g);
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin errors++; $display("FAIL pre_regrant: got %h expected %h", g, e); end
    early = 1'b0;
    for (int b = 0; b < 35; b++) begin
      bus.BUS_req   = 1'b1;
      bus.BUS_ready = 1'b1;
      tick();
      bus.BUS_req   = 1'b0;
      bus.BUS_ready = 1'b0;
      tick();
      if (bus.grant !== 8'h01) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL pre_alone: got release while alone expected grant held 01"); end
    bus.DMA = 8'h09;
    tick();
    checks++;
    if (bus.grant !== 8'h00) begin errors++; $display("FAIL pre_saturate: got %h expected 00", bus.grant); end
    exp_q.push_back(8'h08);
    wait_grant(6, cyc, g);
    e = exp_q.pop_front();
    checks++;
    if (g !== e) begin errors++; $display("FAIL pre_sat_next: got %h expected %h", g, e); end
    bus.DMA = 8'h00;
  endtask

  task automatic test_timeout();
    int cyc;
    logic [N-1:0] e;
    apply_reset();
    bus.DMA = 8'h04;
    exp_q.push_back(8'h04);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.grant !== e) begin errors++; $display("FAIL to_grant: got %h expected %h", bus.grant, e); end
    bus.BUS_req   = 1'b1;
    bus.BUS_ready = 1'b0;
    repeat (200) tick();
    checks++;
    if (bus.grant !== 8'h04 || bus.bus_err !== 1'b0) begin
      errors++; $display("FAIL to_early: got grant=%h err=%b expected 04/0", bus.grant, bus.bus_err);
    end
    bus.BUS_ready = 1'b1;
    tick();
    bus.BUS_ready = 1'b0;
    cyc = 0;
    while (bus.bus_err !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 255) begin errors++; $display("FAIL to_cycles: got %0d expected 255", cyc); end
    checks++;
    if (bus.grant !== 8'h00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL to_abort: got grant=%h busy=%b expected 00/0", bus.grant, bus.busy);
    end
    bus.BUS_req = 1'b0;
    exp_q.push_back(8'h04);
    tick();
    checks++;
    if (bus.bus_err !== 1'b0 || bus.grant !== 8'h00) begin
      errors++; $display("FAIL to_pulse: got err=%b grant=%h expected 0/00", bus.bus_err, bus.grant);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.grant !== e) begin errors++; $display("FAIL to_regrant: got %h expected %h", bus.grant, e); end
    bus.DMA = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] e;
    apply_reset();
    bus.DMA = 8'h06;
    exp_q.push_back(8'h02);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.grant !== e) begin errors++; $display("FAIL rm_grant: got %h expected %h", bus.grant, e); end
    bus.BUS_req   = 1'b1;
    bus.BUS_ready = 1'b0;
    tick();
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if (bus.grant !== 8'h00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rm_async: got grant=%h busy=%b expected 00/0", bus.grant, bus.busy);
    end
    tick();
    clr         = 1'b1;
    bus.BUS_req = 1'b0;
    exp_q.push_back(8'h02);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.grant !== e) begin errors++; $display("FAIL rm_rrptr: got %h expected %h", bus.grant, e); end
    bus.DMA = 8'h00;
  endtask

  task automatic test_drop_mid();
    logic [N-1:0] e;
    apply_reset();
    bus.DMA = 8'h01;
    exp_q.push_back(8'h01);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (bus.grant !== e) begin errors++; $display("FAIL dm_grant: got %h expected %h", bus.grant, e); end
    bus.BUS_req   = 1'b1;
    bus.BUS_ready = 1'b0;
    tick();
    bus.DMA = 8'h00;
    tick();
    checks++;
    if (bus.grant !== 8'h01 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL dm_hold: got grant=%h busy=%b expected 01/1", bus.grant, bus.busy);
    end
    bus.BUS_ready = 1'b1;
    tick();
    checks++;
    if (bus.grant !== 8'h01) begin errors++; $display("FAIL dm_beat: got %h expected 01", bus.grant); end
    bus.BUS_req   = 1'b0;
    bus.BUS_ready = 1'b0;
    tick();
    checks++;
    if (bus.grant !== 8'h00) begin errors++; $display("FAIL dm_release: got %h expected 00", bus.grant); end
    tick();
    checks++;
    if (bus.grant !== 8'h00) begin errors++; $display("FAIL dm_idle: got %h expected 00", bus.grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_timeout();
    test_reset_mid();
    test_drop_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
